vga_scanout_controller: RTL and testbench

- Sequences pixel delivery into the vga timing block.
- Fetches pixels from a synchronous-read frame buffer in raster order, buffers them in a small prefetch FIFO, and presents them on a ready/valid stream with rgb_last_o on the final pixel of each frame.
- Handles start/stop and recovers from sink-reported sync errors by flushing and restarting at pixel 0.
- Sits between the frame-buffer RAM and the vga sink's rgb_* interface.

---
 rtl/vga_scanout_controller.sv | 148 ++++++++++++++
 tb/tb_vga_scanout_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout_controller.sv
// Raster-order frame-buffer fetcher with a small prefetch FIFO feeding the vga rgb stream.
// Supports start/stop-at-frame-end and flush/restart on sink sync errors.
//
// state  | meaning
// IDLE   | no fetch, no stream; waiting for start_i
// FILL   | fetching, stream held off until the prefetch FIFO is full
// STREAM | fetching and streaming; an empty FIFO just drops valid
// DRAIN  | fetch halted after the last pixel of the frame; emptying FIFO
module vga_scanout_controller #(
  parameter int RED_BITS   = 4,
  parameter int GREEN_BITS = 4,
  parameter int BLUE_BITS  = 4,
  parameter int X_DISPLAY  = 10,
  parameter int Y_DISPLAY  = 10,
  parameter int ADDR_WIDTH = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    start_i,
  input  logic                                    stop_i,
  input  logic                                    sync_error_i,
  output logic                                    mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0]                   mem_addr_o,
  input  logic [RED_BITS+GREEN_BITS+BLUE_BITS-1:0] mem_rd_data_i,
  input  logic                                    rgb_ready_i,
  output logic                                    rgb_valid_o,
  output logic [RED_BITS-1:0]                     rgb_data_red_o,
  output logic [GREEN_BITS-1:0]                   rgb_data_green_o,
  output logic [BLUE_BITS-1:0]                    rgb_data_blue_o,
  output logic                                    rgb_last_o,
  output logic                                    busy_o,
  output logic [15:0]                             frame_count_o,
  output logic [7:0]                              error_count_o
);

  localparam int PIX_W = RED_BITS + GREEN_BITS + BLUE_BITS;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(X_DISPLAY * Y_DISPLAY - 1);
  localparam logic [LVL_W-1:0]      FULL_LVL  = LVL_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic [1:0]            state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  inflight, inflight_last;
  logic                  stop_pending;
  logic [PIX_W-1:0]      fifo_data [FIFO_DEPTH];
  logic                  fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [LVL_W-1:0]      level;
  logic [15:0]           frame_count;
  logic [7:0]            error_count;

  logic             fetching, room, issue, flush, stop_req, pop, head_last, at_last;
  logic [LVL_W:0]   occupancy;
  logic [PIX_W-1:0] head;

  assign fetching  = (state == S_FILL) || (state == S_STREAM);
  assign occupancy = {1'b0, level} + {{LVL_W{1'b0}}, inflight};
  assign room      = occupancy < {1'b0, FULL_LVL};
  // A read issued alongside a flush would be discarded anyway, so suppress it.
  assign issue     = fetching && room && !sync_error_i;
  assign flush     = sync_error_i && (state != S_IDLE);
  assign stop_req  = stop_pending || (stop_i && fetching);
  assign at_last   = (addr == LAST_ADDR);
  assign head      = fifo_data[rd_ptr];
  assign head_last = fifo_last[rd_ptr];
  assign pop       = rgb_valid_o && rgb_ready_i;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_i) state_nxt = S_FILL;
      S_FILL: begin
        if (issue && at_last && stop_req) state_nxt = S_DRAIN;
        else if (level == FULL_LVL)       state_nxt = S_STREAM;
      end
      S_STREAM: if (issue && at_last && stop_req) state_nxt = S_DRAIN;
      S_DRAIN:  if (pop && head_last) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = stop_req ? S_IDLE : S_FILL;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      addr          <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      stop_pending  <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      frame_count   <= '0;
      error_count   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      state <= state_nxt;
      if (state_nxt == S_IDLE)    stop_pending <= 1'b0;
      else if (stop_i && fetching) stop_pending <= 1'b1;

      if (pop && head_last) frame_count <= frame_count + 16'd1;

      if (flush) begin
        addr     <= '0;
        inflight <= 1'b0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        level    <= '0;
        if (error_count != 8'hFF) error_count <= error_count + 8'd1;
      end else begin
        if (state == S_IDLE && start_i) addr <= '0;
        else if (issue)                 addr <= at_last ? '0 : addr + ADDR_WIDTH'(1);
        inflight      <= issue;
        inflight_last <= at_last;
        if (inflight) begin
          fifo_data[wr_ptr] <= mem_rd_data_i;
          fifo_last[wr_ptr] <= inflight_last;
          wr_ptr            <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        if (inflight && !pop)      level <= level + LVL_W'(1);
        else if (!inflight && pop) level <= level - LVL_W'(1);
      end
    end
  end

  assign mem_rd_en_o      = issue;
  assign mem_addr_o       = addr;
  assign rgb_valid_o      = (level != '0) && ((state == S_STREAM) || (state == S_DRAIN));
  assign rgb_data_red_o   = head[PIX_W-1 -: RED_BITS];
  assign rgb_data_green_o = head[BLUE_BITS +: GREEN_BITS];
  assign rgb_data_blue_o  = head[BLUE_BITS-1:0];
  assign rgb_last_o       = head_last;
  assign busy_o           = (state != S_IDLE);
  assign frame_count_o    = frame_count;
  assign error_count_o    = error_count;

endmodule

// File: tb/tb_vga_scanout_controller.sv
// Directed bench for vga_scanout_controller on a 4x2 frame with a 4-deep FIFO.
// Frame-buffer model returns the read address as pixel data.
module tb_vga_scanout_controller;
  localparam int AW = 3;
  localparam int FD = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          start_i, stop_i, sync_error_i, rgb_ready_i;
  logic          mem_rd_en_o;
  logic [AW-1:0] mem_addr_o;
  logic [11:0]   mem_rd_data_i;
  logic          rgb_valid_o, rgb_last_o, busy_o;
  logic [3:0]    rgb_data_red_o, rgb_data_green_o, rgb_data_blue_o;
  logic [15:0]   frame_count_o;
  logic [7:0]    error_count_o;
  logic [11:0]   pix;

  always #5 clock = ~clock;

  vga_scanout_controller #(
    .RED_BITS(4), .GREEN_BITS(4), .BLUE_BITS(4),
    .X_DISPLAY(4), .Y_DISPLAY(2), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)
  ) dut (
    .clock(clock), .reset(reset), .start_i(start_i), .stop_i(stop_i),
    .sync_error_i(sync_error_i), .mem_rd_en_o(mem_rd_en_o), .mem_addr_o(mem_addr_o),
    .mem_rd_data_i(mem_rd_data_i), .rgb_ready_i(rgb_ready_i), .rgb_valid_o(rgb_valid_o),
    .rgb_data_red_o(rgb_data_red_o), .rgb_data_green_o(rgb_data_green_o),
    .rgb_data_blue_o(rgb_data_blue_o), .rgb_last_o(rgb_last_o), .busy_o(busy_o),
    .frame_count_o(frame_count_o), .error_count_o(error_count_o)
  );

  assign pix = {rgb_data_red_o, rgb_data_green_o, rgb_data_blue_o};

  always @(posedge clock) if (mem_rd_en_o) mem_rd_data_i <= {9'd0, mem_addr_o};

  int checks = 0;
  int errors = 0;
  int exp_pix, exp_frames, rd_cnt, pop_cnt, extra_reads, last_pop;
  bit stop_armed, halted, found;

  typedef struct {
    bit start; bit ready;
    bit rd; int addr; bit valid; int data; bit last; bit busy; int frames;
  } vec_t;
  vec_t tv [16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_sb();
    exp_pix = 0; exp_frames = 0; rd_cnt = 0; pop_cnt = 0;
    extra_reads = 0; last_pop = -1; stop_armed = 0; halted = 0;
  endtask

  // Sample just before the active edge, update the model, then move to the next negedge.
  task automatic tick();
    #1;
    if (mem_rd_en_o) begin
      rd_cnt++;
      if (halted) extra_reads++;
      if (stop_armed && mem_addr_o == 3'd7) halted = 1;
    end
    if (rgb_valid_o && rgb_ready_i) begin
      chk("pop_data", int'(pix), exp_pix);
      chk("pop_last", int'(rgb_last_o), int'(exp_pix == 7));
      last_pop = int'(pix);
      if (exp_pix == 7) exp_frames++;
      exp_pix = (exp_pix + 1) % 8;
      pop_cnt++;
    end
    if (sync_error_i && busy_o) begin
      exp_pix = 0; rd_cnt = 0; pop_cnt = 0;
    end
    @(negedge clock);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_en"}, int'(mem_rd_en_o), 0);
    chk({tag, "_addr"},  int'(mem_addr_o), 0);
    chk({tag, "_valid"}, int'(rgb_valid_o), 0);
    chk({tag, "_data"},  int'(pix), 0);
    chk({tag, "_last"},  int'(rgb_last_o), 0);
    chk({tag, "_busy"},  int'(busy_o), 0);
    chk({tag, "_frames"}, int'(frame_count_o), 0);
    chk({tag, "_errors"}, int'(error_count_o), 0);
  endtask

  initial begin
    //          st rdy rd addr v data l busy frames
    tv[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
    tv[1]  = '{0, 1, 1, 0, 0, 0, 0, 1, 0};
    tv[2]  = '{0, 1, 1, 1, 0, 0, 0, 1, 0};
    tv[3]  = '{0, 1, 1, 2, 0, 0, 0, 1, 0};
    tv[4]  = '{0, 1, 1, 3, 0, 0, 0, 1, 0};
    tv[5]  = '{0, 1, 0, 4, 0, 0, 0, 1, 0};
    tv[6]  = '{0, 1, 0, 4, 0, 0, 0, 1, 0};
    tv[7]  = '{0, 1, 0, 4, 1, 0, 0, 1, 0};
    tv[8]  = '{0, 1, 1, 4, 1, 1, 0, 1, 0};
    tv[9]  = '{0, 1, 1, 5, 1, 2, 0, 1, 0};
    tv[10] = '{0, 1, 1, 6, 1, 3, 0, 1, 0};
    tv[11] = '{0, 1, 1, 7, 1, 4, 0, 1, 0};
    tv[12] = '{0, 1, 1, 0, 1, 5, 0, 1, 0};
    tv[13] = '{0, 1, 1, 1, 1, 6, 0, 1, 0};
    tv[14] = '{0, 1, 1, 2, 1, 7, 1, 1, 0};
    tv[15] = '{0, 1, 1, 3, 1, 0, 0, 1, 1};

    reset = 1'b1; start_i = 0; stop_i = 0; sync_error_i = 0; rgb_ready_i = 0;
    clear_sb();
    repeat (2) @(negedge clock);
    #1 check_zero("reset");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Startup and first frame, cycle by cycle
    for (int i = 0; i < 16; i++) begin
      start_i = tv[i].start; rgb_ready_i = tv[i].ready;
      #1;
      chk($sformatf("v%0d_rd_en", i),  int'(mem_rd_en_o), int'(tv[i].rd));
      chk($sformatf("v%0d_addr", i),   int'(mem_addr_o), tv[i].addr);
      chk($sformatf("v%0d_valid", i),  int'(rgb_valid_o), int'(tv[i].valid));
      chk($sformatf("v%0d_busy", i),   int'(busy_o), int'(tv[i].busy));
      chk($sformatf("v%0d_frames", i), int'(frame_count_o), tv[i].frames);
      if (tv[i].valid) begin
        chk($sformatf("v%0d_data", i), int'(pix), tv[i].data);
        chk($sformatf("v%0d_last", i), int'(rgb_last_o), int'(tv[i].last));
      end
      tick();
    end
    start_i = 0;

    // Back-pressure: hold ready low for 10 cycles
    rgb_ready_i = 0;
    #1 last_pop = int'(pix);
    tick();
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("stall_valid", int'(rgb_valid_o), 1);
      chk("stall_data", int'(pix), last_pop);
      tick();
    end
    #1;
    chk("stall_rd_en", int'(mem_rd_en_o), 0);
    chk("stall_outstanding", rd_cnt - pop_cnt, FD);
    rgb_ready_i = 1;
    repeat (20) tick();

    // Asynchronous reset in the middle of streaming
    reset = 1'b1;
    #1 check_zero("midrst");
    clear_sb();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1 chk("postrst_valid", int'(rgb_valid_o), 0);
      tick();
    end

    // Stop during pixel 2 of frame 0
    start_i = 1; tick(); start_i = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      #1;
      if (rgb_valid_o && pix == 12'd2) found = 1;
      else tick();
    end
    chk("stop_found_pix2", int'(found), 1);
    stop_i = 1; stop_armed = 1; tick(); stop_i = 0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      #1;
      if (rgb_valid_o && rgb_ready_i && rgb_last_o) found = 1;
      tick();
    end
    chk("stop_last_popped", int'(found), 1);
    #1;
    chk("stop_last_data", last_pop, 7);
    chk("stop_busy", int'(busy_o), 0);
    chk("stop_valid", int'(rgb_valid_o), 0);
    chk("stop_frames", int'(frame_count_o), exp_frames);
    chk("stop_frames_one", int'(frame_count_o), 1);
    chk("stop_extra_reads", extra_reads, 0);
    tick();
    stop_armed = 0; halted = 0;

    // Sync error while the head pixel is 5
    start_i = 1; tick(); start_i = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      #1;
      if (rgb_valid_o && pix == 12'd5) found = 1;
      else tick();
    end
    chk("sync_found_pix5", int'(found), 1);
    sync_error_i = 1; tick(); sync_error_i = 0;
    #1;
    chk("sync_valid", int'(rgb_valid_o), 0);
    chk("sync_errors", int'(error_count_o), 1);
    chk("sync_refetch_en", int'(mem_rd_en_o), 1);
    chk("sync_refetch_addr", int'(mem_addr_o), 0);
    chk("sync_busy", int'(busy_o), 1);
    tick();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (rgb_valid_o) found = 1;
      else tick();
    end
    chk("sync_refill_valid", int'(found), 1);
    chk("sync_first_pix", int'(pix), 0);
    tick();

    // Sync error together with stop while streaming
    sync_error_i = 1; stop_i = 1; tick(); sync_error_i = 0; stop_i = 0;
    #1;
    chk("syncstop_busy", int'(busy_o), 0);
    chk("syncstop_valid", int'(rgb_valid_o), 0);
    chk("syncstop_errors", int'(error_count_o), 2);
    repeat (5) tick();
    chk("syncstop_reads", rd_cnt, 0);

    // Error counter saturation
    start_i = 1; tick(); start_i = 0;
    sync_error_i = 1;
    repeat (253) tick();
    #1 chk("err_at_ff", int'(error_count_o), 255);
    repeat (3) tick();
    #1;
    chk("err_saturated", int'(error_count_o), 255);
    chk("err_busy", int'(busy_o), 1);
    sync_error_i = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
